pc_gen_btb: RTL and testbench

//  Parametrised PC generator with a direct-mapped branch target buffer (BTB).

---
 rtl/pc_gen_btb_pkg.sv | 32 +++
 rtl/pc_gen_btb_btb_dm.sv | 80 ++++++++
 rtl/pc_gen_btb.sv | 70 +++++++
 tb/tb_pc_gen_btb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_btb_pkg.sv
// Shared constants and helpers for the PC generator and its branch target buffer.
package pc_gen_btb_pkg;

    // Default reset address for the fetch PC.
    localparam logic [31:0] CpuResetAddr = 32'h0000_0000;

    // Hold level at or above which the PC is frozen.
    localparam logic [2:0]  Hold_Pc      = 3'd1;

    // 2-bit saturating direction counter encodings.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,   // strongly not taken
        CTR_WNT = 2'b01,   // weakly not taken (reset value)
        CTR_WT  = 2'b10,   // weakly taken (allocation value)
        CTR_ST  = 2'b11    // strongly taken
    } ctr_e;

    // Saturating step of a direction counter towards the resolved outcome.
    function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_gen_btb_btb_dm.sv
// Direct-mapped BTB: per-entry valid/tag/target/counter, combinational read
// port on the fetch PC and a registered write port for branch resolutions.
module btb_dm
    import pc_gen_btb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q  [BTB_ENTRIES];
    ctr_e              ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0] target_q [BTB_ENTRIES];

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_alloc;
    logic              unused_lsbs;

    // Instruction-aligned PCs: the two byte-offset bits never take part.
    assign unused_lsbs = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup on the current fetch PC; reads the stored state, never the update in flight.
    always_comb begin
        rd_idx        = rd_pc_i[IDX_W+1:2];
        rd_tag        = rd_pc_i[ADDR_W-1:IDX_W+2];
        rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken_o  = rd_hit && ctr_q[rd_idx][1];
        pred_target_o = pred_taken_o ? target_q[rd_idx] : '0;
    end

    // Classify the resolved branch: train an existing entry or allocate a new one.
    always_comb begin
        upd_idx   = upd_pc_i[IDX_W+1:2];
        upd_tag   = upd_pc_i[ADDR_W-1:IDX_W+2];
        upd_hit   = upd_valid_i && valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_alloc = upd_valid_i && !upd_hit && upd_taken_i;
    end

    // Valid bits and direction counters; reset clears the table and beats any update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd_hit) begin
            ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken_i);
        end else if (upd_alloc) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= CTR_WT;
        end
    end

    // Tag and target storage; no reset needed since valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rst && (upd_alloc || (upd_hit && upd_taken_i))) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch PC generator: PC register plus next-PC priority mux fed by the BTB.
module pc_gen_btb
    import pc_gen_btb_pkg::*;
#(
    parameter int unsigned      ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR   = ADDR_W'(CpuResetAddr),
    parameter int unsigned      BTB_ENTRIES   = 16,
    parameter int unsigned      INST_BYTES    = 4,
    parameter int unsigned      HOLD_W        = 3,
    parameter logic [HOLD_W-1:0] HOLD_PC_LEVEL = HOLD_W'(Hold_Pc)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_reset_flag_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    btb_dm #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .rd_pc_i       (pc_q),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i)
    );

    // Next-PC selection: debug reset, then redirect, then hold, then prediction, then sequential.
    always_comb begin
        pc_d = pc_q + ADDR_W'(INST_BYTES);
        if (jtag_reset_flag_i) begin
            pc_d = RESET_ADDR;
        end else if (jump_flag_i) begin
            pc_d = jump_addr_i;
        end else if (hold_flag_i >= HOLD_PC_LEVEL) begin
            pc_d = pc_q;
        end else if (pred_taken_o) begin
            pc_d = pred_target_o;
        end
    end

    // Fetch PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Self-checking bench for pc_gen_btb: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural fetch/BTB model.
module tb_pc_gen_btb;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag_reset_flag_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    always #5 clk = ~clk;

    pc_gen_btb dut (
        .clk               (clk),
        .rst               (rst),
        .jtag_reset_flag_i (jtag_reset_flag_i),
        .jump_flag_i       (jump_flag_i),
        .jump_addr_i       (jump_addr_i),
        .hold_flag_i       (hold_flag_i),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .pc_o              (pc_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Prediction for a PC: entry chosen by word address mod N, tag is the word address / N.
    function automatic void m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int idx;
        idx = int'((pc / 4) % N);
        tk  = m_valid[idx] && (m_tag[idx] == pc / (4 * N)) && (m_ctr[idx] >= 2);
        tg  = tk ? m_tgt[idx] : 32'h0;
    endfunction

    // One clock: drive inputs, predict the next PC, advance, then compare.
    task automatic step(input bit r, input bit jt, input bit jp, input logic [31:0] ja,
                        input logic [2:0] h, input bit uv, input logic [31:0] up,
                        input bit ut, input logic [31:0] utg);
        bit          tk;
        logic [31:0] tg;
        logic [31:0] nxt;
        int          idx;
        bit          hit;
        rst = r; jtag_reset_flag_i = jt; jump_flag_i = jp; jump_addr_i = ja;
        hold_flag_i = h; upd_valid_i = uv; upd_pc_i = up; upd_taken_i = ut; upd_target_i = utg;
        m_lookup(m_pc, tk, tg);
        if (!r || jt)   nxt = 32'h0;
        else if (jp)    nxt = ja;
        else if (h >= 1) nxt = m_pc;
        else if (tk)    nxt = tg;
        else            nxt = m_pc + 32'd4;
        @(posedge clk);
        #1;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else if (uv) begin
            idx = int'((up / 4) % N);
            hit = m_valid[idx] && (m_tag[idx] == up / (4 * N));
            if (hit) begin
                m_ctr[idx] = ut ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                if (ut) m_tgt[idx] = utg;
            end else if (ut) begin
                m_valid[idx] = 1;
                m_tag[idx]   = up / (4 * N);
                m_tgt[idx]   = utg;
                m_ctr[idx]   = 2;
            end
        end
        m_pc = nxt;
        m_lookup(m_pc, tk, tg);
        check32("pc", pc_o, m_pc);
        check32("pred_taken", {31'h0, pred_taken_o}, {31'h0, tk});
        check32("pred_target", pred_target_o, tg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] a);
        step(1, 0, 1, a, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] p, input bit t, input logic [31:0] tg);
        step(1, 0, 0, 0, 0, 1, p, t, tg);
    endtask

    initial begin
        m_pc = 32'h0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end

        // Reset for two cycles (an update during reset must be ignored), then count up.
        step(0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h40);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Train 0x10 taken -> 0x40, then pass through it.
        upd(32'h10, 1, 32'h40);
        jump(32'h0);
        idle(7);

        // Hysteresis: not-taken, pass; not-taken; taken; pass.
        upd(32'h10, 0, 32'h0);
        jump(32'h0);
        idle(7);
        upd(32'h10, 0, 32'h0);
        upd(32'h10, 1, 32'h40);
        jump(32'h0);
        idle(7);
        upd(32'h10, 1, 32'h40);
        jump(32'h0);
        idle(7);

        // Priority: jump beats hold and a predicted hit; hold alone freezes.
        jump(32'h10);
        step(1, 0, 1, 32'h100, 3'd2, 0, 0, 0, 0);
        jump(32'h10);
        step(1, 0, 0, 0, 3'd2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3'd1, 0, 0, 0, 0);
        idle(2);

        // Update and lookup on the same index in one cycle: lookup sees the old entry.
        jump(32'h10);
        upd(32'h10, 1, 32'h60);
        idle(3);

        // Alias/eviction: 0x50 shares index with 0x10.
        upd(32'h50, 1, 32'h80);
        jump(32'h10);
        idle(3);
        jump(32'h50);
        idle(3);

        // Wrap at the top of the address space.
        jump(32'hFFFF_FFFC);
        idle(3);

        // JTAG reset mid-run keeps the trained entry.
        jump(32'h44);
        idle(2);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(24);

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            bit          r, jt, jp, uv, ut;
            logic [31:0] ja, up, utg;
            logic [2:0]  h;
            r   = ($urandom_range(0, 63) != 0);
            jt  = ($urandom_range(0, 31) == 0);
            jp  = ($urandom_range(0, 7) == 0);
            ja  = 32'($urandom_range(0, 63)) * 32'd4;
            h   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            uv  = ($urandom_range(0, 2) == 0);
            up  = 32'($urandom_range(0, 63)) * 32'd4;
            ut  = 1'($urandom_range(0, 1));
            utg = 32'($urandom_range(0, 63)) * 32'd4;
            step(r, jt, jp, ja, h, uv, up, ut, utg);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
